// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: control word, opcode encoding, memory FSM state.
package lc3b_types;

    localparam int unsigned REG_W = 3;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode opcode;
        logic       regFile_load;
        logic       mem2_read;
        logic       mem2_write;
    } lc3b_control;

    localparam lc3b_control CTRL_NOP = '{
        opcode:       op_br,
        regFile_load: 1'b0,
        mem2_read:    1'b0,
        mem2_write:   1'b0
    };

    typedef enum logic {
        M_IDLE = 1'b0,
        M_WAIT = 1'b1
    } mem_state_t;

    // Opcodes whose result is only available after the data-memory access.
    function automatic logic is_mem_load(input lc3b_opcode op);
        return (op == op_ldr) || (op == op_ldb) || (op == op_ldi);
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage register: control word, valid flag and destination register.
module ctrl_stage_reg
    import lc3b_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              bubble,
    input  lc3b_control       nxt_ctrl,
    input  logic              nxt_valid,
    input  logic [REG_W-1:0]  nxt_dest,
    output lc3b_control       ctrl,
    output logic              valid,
    output logic [REG_W-1:0]  dest
);

    // Bubble wins over load; neither means hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl  <= CTRL_NOP;
            valid <= 1'b0;
            dest  <= '0;
        end else if (bubble) begin
            ctrl  <= CTRL_NOP;
            valid <= 1'b0;
            dest  <= '0;
        end else if (load) begin
            ctrl  <= nxt_ctrl;
            valid <= nxt_valid;
            dest  <= nxt_dest;
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// EX/MEM/WB control pipeline with memory-stall, flush and load-use hazard handling.
module ctrl_pipeline
    import lc3b_types::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  lc3b_control       id_ctrl,
    input  logic              id_valid,
    input  logic [REG_W-1:0]  id_dest,
    input  logic [REG_W-1:0]  id_sr1,
    input  logic [REG_W-1:0]  id_sr2,
    input  logic              flush,
    input  logic              dmem_resp,
    output lc3b_control       ex_ctrl,
    output lc3b_control       mem_ctrl,
    output lc3b_control       wb_ctrl,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic [REG_W-1:0]  wb_dest,
    output logic              stall_id,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic              regfile_we
);

    logic [REG_W-1:0] ex_dest;
    logic [REG_W-1:0] mem_dest;
    logic             mem_access;
    logic             mem_stall;
    logic             load_use;
    logic             ex_load, ex_bubble;
    logic             mem_load, mem_bubble;
    logic             wb_load, wb_bubble;
    mem_state_t       mem_state, mem_state_nxt;

    assign dmem_read  = mem_valid & mem_ctrl.mem2_read;
    assign dmem_write = mem_valid & mem_ctrl.mem2_write;
    assign regfile_we = wb_valid & wb_ctrl.regFile_load;
    assign mem_access = dmem_read | dmem_write;
    assign mem_stall  = mem_access & ~dmem_resp;

    assign load_use = ex_valid & ex_ctrl.regFile_load & is_mem_load(ex_ctrl.opcode)
                    & id_valid & ((ex_dest == id_sr1) | (ex_dest == id_sr2));

    // Stage steering: mem_stall > flush > load_use > advance.
    always_comb begin
        ex_load    = 1'b1;
        ex_bubble  = 1'b0;
        mem_load   = 1'b1;
        mem_bubble = 1'b0;
        wb_load    = 1'b1;
        wb_bubble  = 1'b0;
        stall_id   = 1'b0;
        if (mem_stall) begin
            ex_load   = 1'b0;
            mem_load  = 1'b0;
            wb_bubble = 1'b1;
            stall_id  = 1'b1;
        end else if (flush) begin
            ex_bubble  = 1'b1;
            mem_bubble = 1'b1;
        end else if (load_use) begin
            ex_bubble = 1'b1;
            stall_id  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_state <= M_IDLE;
        else        mem_state <= mem_state_nxt;
    end

    always_comb begin
        mem_state_nxt = mem_state;
        case (mem_state)
            M_IDLE:  if (mem_stall) mem_state_nxt = M_WAIT;
            M_WAIT:  if (dmem_resp) mem_state_nxt = M_IDLE;
            default: mem_state_nxt = M_IDLE;
        endcase
    end

    ctrl_stage_reg u_ex (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ex_load),
        .bubble    (ex_bubble),
        .nxt_ctrl  (id_ctrl),
        .nxt_valid (id_valid),
        .nxt_dest  (id_dest),
        .ctrl      (ex_ctrl),
        .valid     (ex_valid),
        .dest      (ex_dest)
    );

    ctrl_stage_reg u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (mem_load),
        .bubble    (mem_bubble),
        .nxt_ctrl  (ex_ctrl),
        .nxt_valid (ex_valid),
        .nxt_dest  (ex_dest),
        .ctrl      (mem_ctrl),
        .valid     (mem_valid),
        .dest      (mem_dest)
    );

    ctrl_stage_reg u_wb (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (wb_load),
        .bubble    (wb_bubble),
        .nxt_ctrl  (mem_ctrl),
        .nxt_valid (mem_valid),
        .nxt_dest  (mem_dest),
        .ctrl      (wb_ctrl),
        .valid     (wb_valid),
        .dest      (wb_dest)
    );

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: advance, load-use, memory wait, flush and reset cases.
module tb_ctrl_pipeline;
    import lc3b_types::*;

    logic             clk;
    logic             rst_n;
    lc3b_control      id_ctrl;
    logic             id_valid;
    logic [REG_W-1:0] id_dest, id_sr1, id_sr2;
    logic             flush, dmem_resp;
    lc3b_control      ex_ctrl, mem_ctrl, wb_ctrl;
    logic             ex_valid, mem_valid, wb_valid;
    logic [REG_W-1:0] wb_dest;
    logic             stall_id, dmem_read, dmem_write, regfile_we;

    int checks   = 0;
    int failures = 0;

    ctrl_pipeline dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_ctrl    (id_ctrl),
        .id_valid   (id_valid),
        .id_dest    (id_dest),
        .id_sr1     (id_sr1),
        .id_sr2     (id_sr2),
        .flush      (flush),
        .dmem_resp  (dmem_resp),
        .ex_ctrl    (ex_ctrl),
        .mem_ctrl   (mem_ctrl),
        .wb_ctrl    (wb_ctrl),
        .ex_valid   (ex_valid),
        .mem_valid  (mem_valid),
        .wb_valid   (wb_valid),
        .wb_dest    (wb_dest),
        .stall_id   (stall_id),
        .dmem_read  (dmem_read),
        .dmem_write (dmem_write),
        .regfile_we (regfile_we)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic lc3b_control mk(input lc3b_opcode op, input logic rf,
                                       input logic rd, input logic wr);
        lc3b_control c;
        c.opcode       = op;
        c.regFile_load = rf;
        c.mem2_read    = rd;
        c.mem2_write   = wr;
        return c;
    endfunction

    task automatic issue(input lc3b_control c, input logic [REG_W-1:0] d,
                         input logic [REG_W-1:0] s1, input logic [REG_W-1:0] s2);
        id_ctrl  = c;
        id_valid = 1'b1;
        id_dest  = d;
        id_sr1   = s1;
        id_sr2   = s2;
    endtask

    task automatic idle;
        id_ctrl  = CTRL_NOP;
        id_valid = 1'b0;
        id_dest  = '0;
        id_sr1   = '0;
        id_sr2   = '0;
    endtask

    task automatic drain;
        idle();
        flush     = 1'b0;
        dmem_resp = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        dmem_resp = 1'b0;
        idle();
        tick();
        tick();

        // Reset state
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_mem_ctrl", 32'(mem_ctrl), 32'(CTRL_NOP));
        check("rst_stall", 32'(stall_id), 32'd0);
        check("rst_fsm", 32'(dut.mem_state), 32'(M_IDLE));
        rst_n = 1'b1;
        tick();

        // ADD R1 flows ID->EX->MEM->WB
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd1, 3'd2, 3'd3);
        tick();
        check("add_ex_valid", 32'(ex_valid), 32'd1);
        idle();
        tick();
        check("add_mem_valid", 32'(mem_valid), 32'd1);
        check("add_ex_empty", 32'(ex_valid), 32'd0);
        tick();
        check("add_wb_valid", 32'(wb_valid), 32'd1);
        check("add_regfile_we", 32'(regfile_we), 32'd1);
        check("add_wb_dest", 32'(wb_dest), 32'd1);
        drain();

        // LDR R2 then dependent ADD R3,R2,R4: one-cycle load-use stall
        issue(mk(op_ldr, 1'b1, 1'b1, 1'b0), 3'd2, 3'd5, 3'd5);
        tick();
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd3, 3'd2, 3'd4);
        dmem_resp = 1'b1;
        #1;
        check("lu_stall", 32'(stall_id), 32'd1);
        tick();
        check("lu_ex_bubble", 32'(ex_valid), 32'd0);
        check("lu_ldr_mem", 32'(dmem_read), 32'd1);
        check("lu_stall_once", 32'(stall_id), 32'd0);
        tick();
        check("lu_add_ex", 32'(ex_valid), 32'd1);
        check("lu_add_op", 32'(ex_ctrl.opcode), 32'(op_add));
        check("lu_ldr_wb", 32'(wb_dest), 32'd2);
        drain();

        // STR in MEM, response three cycles later; ADD behind it must hold in EX
        issue(mk(op_str, 1'b0, 1'b0, 1'b1), 3'd0, 3'd1, 3'd2);
        tick();
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd5, 3'd1, 3'd1);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dmem_resp = 1'b1;
            #1;
            check($sformatf("st_write_%0d", i), 32'(dmem_write), 32'd1);
            check($sformatf("st_stall_%0d", i), 32'(stall_id), (i < 3) ? 32'd1 : 32'd0);
            tick();
            if (i < 3) begin
                check($sformatf("st_wb_bubble_%0d", i), 32'(wb_valid), 32'd0);
                check($sformatf("st_ex_hold_%0d", i), 32'(ex_ctrl.opcode), 32'(op_add));
                check($sformatf("st_fsm_wait_%0d", i), 32'(dut.mem_state), 32'(M_WAIT));
            end
        end
        dmem_resp = 1'b0;
        #1;
        check("st_fsm_idle", 32'(dut.mem_state), 32'(M_IDLE));
        check("st_wb_valid", 32'(wb_valid), 32'd1);
        check("st_no_we", 32'(regfile_we), 32'd0);
        check("st_add_mem", 32'(mem_valid), 32'd1);
        check("st_write_done", 32'(dmem_write), 32'd0);
        drain();

        // Flush with valid EX and ID; MEM instruction still reaches WB
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd1, 3'd0, 3'd0);
        tick();
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd2, 3'd0, 3'd0);
        tick();
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd3, 3'd0, 3'd0);
        flush = 1'b1;
        #1;
        check("fl_no_stall", 32'(stall_id), 32'd0);
        tick();
        flush = 1'b0;
        idle();
        check("fl_ex_kill", 32'(ex_valid), 32'd0);
        check("fl_mem_kill", 32'(mem_valid), 32'd0);
        check("fl_wb_valid", 32'(wb_valid), 32'd1);
        check("fl_wb_dest", 32'(wb_dest), 32'd1);
        check("fl_wb_we", 32'(regfile_we), 32'd1);
        drain();

        // Flush held during an LDR wait takes effect only on the release edge
        issue(mk(op_ldr, 1'b1, 1'b1, 1'b0), 3'd6, 3'd1, 3'd1);
        tick();
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd4, 3'd1, 3'd1);
        tick();
        idle();
        flush = 1'b1;
        #1;
        check("fw_stall", 32'(stall_id), 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            check($sformatf("fw_ex_hold_%0d", i), 32'(ex_valid), 32'd1);
            check($sformatf("fw_mem_hold_%0d", i), 32'(mem_valid), 32'd1);
            check($sformatf("fw_wb_bubble_%0d", i), 32'(wb_valid), 32'd0);
        end
        dmem_resp = 1'b1;
        #1;
        check("fw_release_nostall", 32'(stall_id), 32'd0);
        tick();
        dmem_resp = 1'b0;
        flush     = 1'b0;
        check("fw_ex_kill", 32'(ex_valid), 32'd0);
        check("fw_mem_kill", 32'(mem_valid), 32'd0);
        check("fw_ldr_wb", 32'(wb_dest), 32'd6);
        check("fw_ldr_we", 32'(regfile_we), 32'd1);
        check("fw_fsm_idle", 32'(dut.mem_state), 32'(M_IDLE));
        drain();

        // Reset asserted while waiting on a store
        issue(mk(op_str, 1'b0, 1'b0, 1'b1), 3'd0, 3'd1, 3'd2);
        tick();
        idle();
        tick();
        tick();
        check("rw_fsm_wait", 32'(dut.mem_state), 32'(M_WAIT));
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_mem_valid", 32'(mem_valid), 32'd0);
        check("rw_dmem_write", 32'(dmem_write), 32'd0);
        check("rw_stall", 32'(stall_id), 32'd0);
        check("rw_mem_ctrl", 32'(mem_ctrl), 32'(CTRL_NOP));
        check("rw_fsm_idle", 32'(dut.mem_state), 32'(M_IDLE));
        rst_n = 1'b1;
        tick();
        check("rw_post_empty", 32'(mem_valid), 32'd0);
        issue(mk(op_add, 1'b1, 1'b0, 1'b0), 3'd7, 3'd0, 3'd0);
        tick();
        idle();
        tick();
        tick();
        check("rw_refill_wb", 32'(wb_valid), 32'd1);
        check("rw_refill_dest", 32'(wb_dest), 32'd7);
        check("rw_refill_we", 32'(regfile_we), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ctrl_pipeline.md
CTRL_PIPELINE -- requirements
Module: ctrl_pipeline

Interface
REQ-001 Clocking and reset SHALL be one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
REQ-002 ID-stage inputs SHALL be:
- id_ctrl  in  lc3b_control  decoded control word for the instruction in ID
- id_valid  in  1  id_ctrl holds a real instruction
- id_dest  in  3  destination register of ID instruction
- id_sr1  in  3  source register 1 of ID instruction
- id_sr2  in  3  source register 2 of ID instruction
REQ-003 Redirect and memory inputs SHALL be:
- flush  in  1  taken redirect resolved in MEM; kill younger instructions
- dmem_resp  in  1  data memory completes current access
REQ-004 Pipeline outputs SHALL be:
- ex_ctrl, mem_ctrl, wb_ctrl  out  lc3b_control  stage control words
- ex_valid, mem_valid, wb_valid  out  1  stage holds real instruction
- wb_dest  out  3  WB destination register
REQ-005 Stall and strobe outputs SHALL be:
- stall_id  out  1  hold PC and IF/ID register this cycle
- dmem_read  out  1  equals mem_valid & mem_ctrl.mem2_read
- dmem_write  out  1  equals mem_valid & mem_ctrl.mem2_write
- regfile_we  out  1  equals wb_valid & wb_ctrl.regFile_load

Function
REQ-006 Each stage SHALL advance one cycle per edge when not stalled (ID->EX, EX->MEM, MEM->WB), carrying ctrl, valid and dest together.
REQ-007 A bubble SHALL be valid=0, ctrl=CTRL_NOP (all load/read/write bits 0), dest=0.
REQ-008 mem_access SHALL be dmem_read|dmem_write; mem_stall SHALL be mem_access & ~dmem_resp, combinationally.
REQ-009 The memory FSM SHALL have states M_IDLE and M_WAIT: IDLE->WAIT on mem_stall; WAIT->IDLE on dmem_resp; otherwise hold.
REQ-010 While mem_stall: EX and MEM SHALL hold, WB SHALL load a bubble, and stall_id SHALL be 1.
REQ-011 load_use SHALL be ex_valid & ex_ctrl.regFile_load & ex_ctrl.opcode in {op_ldr, op_ldb, op_ldi} & id_valid & (ex dest == id_sr1 or ex dest == id_sr2).
REQ-012 When load_use is set without mem_stall: EX SHALL load a bubble, MEM and WB SHALL advance, and stall_id SHALL be 1.
REQ-013 When flush is set without mem_stall: EX SHALL load a bubble regardless of id_valid, MEM SHALL load a bubble, WB SHALL advance, and stall_id SHALL be 0.
REQ-014 Priority SHALL be mem_stall > flush > load_use; flush SHALL be ignored during mem_stall, and its source SHALL hold it until stall release.
REQ-015 A dmem_resp arriving in the same cycle as the access SHALL produce no stall cycle.
REQ-016 dmem_resp without mem_access SHALL be ignored.

Reset
REQ-017 On rst_n low, all valid outputs SHALL be 0, all ctrl outputs CTRL_NOP, wb_dest 0, FSM M_IDLE, and stall_id, dmem_read, dmem_write and regfile_we 0, immediately and asynchronously.
REQ-018 Reset asserted mid-access SHALL abandon the access; the first post-reset cycle SHALL start from empty stages.

Structure
REQ-019 The lc3b_types package SHALL hold lc3b_control, the opcode enum, CTRL_NOP and the mem FSM state typedef.
REQ-020 One sub-module, ctrl_stage_reg, SHALL hold one stage's ctrl, valid and dest, with inputs load and bubble; it SHALL be instantiated three times.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ADD R1 in ID at cycle 0, no hazards -> ex_valid at cycle 1, mem_valid at cycle 2, wb_valid with regfile_we=1 and wb_dest=1 at cycle 3.
- LDR R2 then ADD R3,R2,R4 -> stall_id=1 for exactly 1 cycle, EX bubble, ADD in EX 2 cycles after LDR.
- STR in MEM, dmem_resp 3 cycles later -> dmem_write=1 for 4 cycles, stall_id=1 for 3, WB bubble for 3, FSM returns to M_IDLE.
- flush with valid EX and ID -> next cycle ex_valid=0 and mem_valid=0; the older WB instruction still writes.
- flush during LDR wait -> no kill until dmem_resp; the kill is applied on the release edge.
- rst_n low during M_WAIT -> all outputs go to zero immediately, and the pipeline refills correctly after release.
